exe_stage: RTL and testbench

Execute stage of the 5-stage RV32IM pipeline. It sits between the ID/EXE boundary and the MEM stage.
- Forwards operands, computes ALU/M-extension results, resolves branches and jumps.
- Registers the EXE/MEM outputs that the MEM stage consumes.
- Division runs on an iterative radix-2 divider that stalls upstream through exe_stall.

---
 rtl/exe_pkg.sv | 80 ++++++++
 rtl/div_iter.sv | 106 ++++++++++
 rtl/exe_stage.sv | 203 ++++++++++++++++++++
 tb/tb_exe_stage.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exe_pkg.sv
// Shared types for the execute stage.
//   alu_op_t    : ALU, multiply and divide operation select (5 bits)
//   ctrl_t      : control bundle arriving from ID/EXE
//   div_state_t : iterative divider state, exposed for observation
//   F3_*        : funct3 encodings of the branch conditions
//   fwd_select  : per-source operand forwarding choice
package exe_pkg;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_SLL    = 5'd2,
        ALU_SLT    = 5'd3,
        ALU_SLTU   = 5'd4,
        ALU_XOR    = 5'd5,
        ALU_SRL    = 5'd6,
        ALU_SRA    = 5'd7,
        ALU_OR     = 5'd8,
        ALU_AND    = 5'd9,
        ALU_LUI    = 5'd10,
        ALU_AUIPC  = 5'd11,
        ALU_MUL    = 5'd12,
        ALU_MULH   = 5'd13,
        ALU_MULHSU = 5'd14,
        ALU_MULHU  = 5'd15,
        ALU_DIV    = 5'd16,
        ALU_DIVU   = 5'd17,
        ALU_REM    = 5'd18,
        ALU_REMU   = 5'd19
    } alu_op_t;

    typedef struct packed {
        logic rd_src;
        logic mem_to_reg;
        logic mem_write;
        logic mem_read;
        logic reg_write;
        logic alu_src;
        logic branch;
        logic jal;
        logic jalr;
    } ctrl_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // MEM result wins over WB result; x0 is never forwarded.
    function automatic logic [31:0] fwd_select(
        input logic [4:0]  addr,
        input logic [31:0] rf_data,
        input logic        mem_we,
        input logic [4:0]  mem_rd,
        input logic [31:0] mem_data,
        input logic        wb_we,
        input logic [4:0]  wb_rd,
        input logic [31:0] wb_data
    );
        logic [31:0] sel;
        sel = rf_data;
        if (addr != 5'd0) begin
            if (mem_we && (mem_rd == addr)) begin
                sel = mem_data;
            end else if (wb_we && (wb_rd == addr)) begin
                sel = wb_data;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider, one quotient bit per cycle.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   start      : begin a divide with a/b (sampled in IDLE only)
//   signed_op  : treat a/b as two's complement (DIV/REM)
//   rem_op     : return the remainder instead of the quotient
//   a, b       : dividend, divisor
//   busy       : high while shift-subtract steps are running
//   done       : one-cycle pulse; result is valid in that same cycle
//   result     : sign-corrected quotient or remainder
//   state      : current FSM state
// Handshake: start is accepted only in IDLE; a/b/signed_op/rem_op are
// captured on that edge and ignored afterwards. Completion is the single
// cycle in which done is high; there is no back-pressure on the result.
module div_iter
    import exe_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        signed_op,
    input  logic        rem_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output div_state_t  state
);

    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] dvs;
    logic [4:0]  cnt;
    logic        neg_q;
    logic        neg_r;
    logic        rem_sel;

    logic [32:0] rem_shift;
    logic [31:0] rem_sub;
    logic        fits;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [31:0] q_fix;
    logic [31:0] r_fix;

    assign abs_a = (signed_op && a[31]) ? (~a + 32'd1) : a;
    assign abs_b = (signed_op && b[31]) ? (~b + 32'd1) : b;

    // Partial remainder stays below the divisor, so the shifted value fits
    // in 33 bits and the difference, when taken, fits back into 32.
    assign rem_shift = {rem, quo[31]};
    assign fits      = (rem_shift >= {1'b0, dvs});
    assign rem_sub   = rem_shift[31:0] - dvs;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 5'd0;
            quo     <= 32'd0;
            rem     <= 32'd0;
            dvs     <= 32'd0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            rem_sel <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        quo     <= abs_a;
                        rem     <= 32'd0;
                        dvs     <= abs_b;
                        // A zero divisor must yield all-ones, so no negation.
                        neg_q   <= signed_op && (a[31] ^ b[31]) && (b != 32'd0);
                        neg_r   <= signed_op && a[31];
                        rem_sel <= rem_op;
                        cnt     <= 5'd0;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    quo <= {quo[30:0], fits};
                    rem <= fits ? rem_sub : rem_shift[31:0];
                    if (cnt == 5'd31) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign q_fix  = neg_q ? (~quo + 32'd1) : quo;
    assign r_fix  = neg_r ? (~rem + 32'd1) : rem;
    assign result = rem_sel ? r_fix : q_fix;
    assign busy   = (state == BUSY);
    assign done   = (state == DONE);

endmodule

// File: rtl/exe_stage.sv
// Execute stage of the RV32IM pipeline: operand forwarding, ALU and
// M-extension results, branch/jump resolution and the EXE/MEM register.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   ID_*                     : instruction fields from the ID/EXE register
//   fwd_mem_data             : rd value currently in MEM
//   fwd_wb_*                 : writeback value, destination and enable
//   EXE_*                    : registered EXE/MEM outputs
//   branch_taken/_target     : combinational redirect to fetch
//   exe_stall                : combinational hold of IF/ID and ID/EXE
module exe_stage
    import exe_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter bit DIV_FASTPATH = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ID_valid,
    input  ctrl_t           ID_ctrl,
    input  alu_op_t         ID_alu_op,
    input  logic [2:0]      ID_funct3,
    input  logic [XLEN-1:0] ID_pc,
    input  logic [XLEN-1:0] ID_imm,
    input  logic [XLEN-1:0] ID_rs1_data,
    input  logic [XLEN-1:0] ID_rs2_data,
    input  logic [4:0]      ID_rs1_addr,
    input  logic [4:0]      ID_rs2_addr,
    input  logic [4:0]      ID_rd_addr,
    input  logic [XLEN-1:0] fwd_mem_data,
    input  logic [XLEN-1:0] fwd_wb_data,
    input  logic [4:0]      fwd_wb_rd_addr,
    input  logic            fwd_wb_RegWrite,
    output logic            EXE_RDSrc,
    output logic            EXE_MemtoReg,
    output logic            EXE_MemWrite,
    output logic            EXE_MemRead,
    output logic            EXE_RegWrite,
    output logic [XLEN-1:0] EXE_pc_to_reg,
    output logic [XLEN-1:0] EXE_ALU_out,
    output logic [XLEN-1:0] EXE_rs2_data,
    output logic [4:0]      EXE_rd_addr,
    output logic [2:0]      EXE_funct3,
    output logic            branch_taken,
    output logic [XLEN-1:0] branch_target,
    output logic            exe_stall
);

    ctrl_t       ctrl_v;
    logic [31:0] rs1_fwd;
    logic [31:0] rs2_fwd;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] alu_result;

    // A bubble carries no control at all.
    assign ctrl_v = ID_valid ? ID_ctrl : '0;

    assign rs1_fwd = fwd_select(ID_rs1_addr, ID_rs1_data, EXE_RegWrite, EXE_rd_addr,
                                fwd_mem_data, fwd_wb_RegWrite, fwd_wb_rd_addr, fwd_wb_data);
    assign rs2_fwd = fwd_select(ID_rs2_addr, ID_rs2_data, EXE_RegWrite, EXE_rd_addr,
                                fwd_mem_data, fwd_wb_RegWrite, fwd_wb_rd_addr, fwd_wb_data);

    assign op_a = rs1_fwd;
    assign op_b = ctrl_v.alu_src ? ID_imm : rs2_fwd;

    // Multiply: 64-bit product of sign/zero-extended operands; the low
    // 64 bits of the modular product are exact for every signedness mix.
    logic        mul_a_sgn;
    logic        mul_b_sgn;
    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic [63:0] product;

    assign mul_a_sgn = (ID_alu_op == ALU_MUL) || (ID_alu_op == ALU_MULH) || (ID_alu_op == ALU_MULHSU);
    assign mul_b_sgn = (ID_alu_op == ALU_MUL) || (ID_alu_op == ALU_MULH);
    assign mul_a     = {{32{mul_a_sgn & op_a[31]}}, op_a};
    assign mul_b     = {{32{mul_b_sgn & op_b[31]}}, op_b};
    assign product   = mul_a * mul_b;

    // Divide: special cases finish combinationally, the rest iterate.
    logic        is_div;
    logic        div_signed;
    logic        div_rem;
    logic        div_zero;
    logic        div_ovf;
    logic        div_fast;
    logic        div_start;
    logic        div_busy;
    logic        div_done;
    logic [31:0] div_result;
    logic [31:0] fast_result;
    div_state_t  div_state;

    assign is_div     = (ID_alu_op == ALU_DIV) || (ID_alu_op == ALU_DIVU) ||
                        (ID_alu_op == ALU_REM) || (ID_alu_op == ALU_REMU);
    assign div_signed = (ID_alu_op == ALU_DIV) || (ID_alu_op == ALU_REM);
    assign div_rem    = (ID_alu_op == ALU_REM) || (ID_alu_op == ALU_REMU);
    assign div_zero   = (op_b == 32'd0);
    assign div_ovf    = div_signed && (op_a == 32'h8000_0000) && (op_b == 32'hFFFF_FFFF);
    assign div_fast   = DIV_FASTPATH && (div_zero || div_ovf);

    assign fast_result = div_rem ? (div_zero ? op_a : 32'd0)
                                 : (div_zero ? 32'hFFFF_FFFF : 32'h8000_0000);

    // Reset gates the start so an aborted divide cannot re-arm the stall
    // while rst is still held.
    assign div_start = ~rst && ID_valid && is_div && !div_fast && (div_state == IDLE);
    assign exe_stall = div_start || div_busy;

    div_iter u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .signed_op (div_signed),
        .rem_op    (div_rem),
        .a         (op_a),
        .b         (op_b),
        .busy      (div_busy),
        .done      (div_done),
        .result    (div_result),
        .state     (div_state)
    );

    always_comb begin
        alu_result = 32'd0;
        case (ID_alu_op)
            ALU_ADD:    alu_result = op_a + op_b;
            ALU_SUB:    alu_result = op_a - op_b;
            ALU_SLL:    alu_result = op_a << op_b[4:0];
            ALU_SLT:    alu_result = {31'd0, $signed(op_a) < $signed(op_b)};
            ALU_SLTU:   alu_result = {31'd0, op_a < op_b};
            ALU_XOR:    alu_result = op_a ^ op_b;
            ALU_SRL:    alu_result = op_a >> op_b[4:0];
            ALU_SRA:    alu_result = $signed(op_a) >>> op_b[4:0];
            ALU_OR:     alu_result = op_a | op_b;
            ALU_AND:    alu_result = op_a & op_b;
            ALU_LUI:    alu_result = ID_imm;
            ALU_AUIPC:  alu_result = ID_pc + ID_imm;
            ALU_MUL:    alu_result = product[31:0];
            ALU_MULH,
            ALU_MULHSU,
            ALU_MULHU:  alu_result = product[63:32];
            ALU_DIV,
            ALU_DIVU,
            ALU_REM,
            ALU_REMU:   alu_result = div_done ? div_result : fast_result;
            default:    alu_result = 32'd0;
        endcase
    end

    // Branch resolution compares the forwarded registers, never the immediate.
    logic cond;
    always_comb begin
        cond = 1'b0;
        case (ID_funct3)
            F3_BEQ:  cond = (rs1_fwd == rs2_fwd);
            F3_BNE:  cond = (rs1_fwd != rs2_fwd);
            F3_BLT:  cond = ($signed(rs1_fwd) <  $signed(rs2_fwd));
            F3_BGE:  cond = ($signed(rs1_fwd) >= $signed(rs2_fwd));
            F3_BLTU: cond = (rs1_fwd <  rs2_fwd);
            F3_BGEU: cond = (rs1_fwd >= rs2_fwd);
            default: cond = 1'b0;
        endcase
    end

    assign branch_taken  = ctrl_v.jal || ctrl_v.jalr || (ctrl_v.branch && cond);
    assign branch_target = ctrl_v.jalr ? ((rs1_fwd + ID_imm) & ~32'd1) : (ID_pc + ID_imm);

    // EXE/MEM register: a stalled cycle inserts a bubble and holds the data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            EXE_RDSrc     <= 1'b0;
            EXE_MemtoReg  <= 1'b0;
            EXE_MemWrite  <= 1'b0;
            EXE_MemRead   <= 1'b0;
            EXE_RegWrite  <= 1'b0;
            EXE_pc_to_reg <= '0;
            EXE_ALU_out   <= '0;
            EXE_rs2_data  <= '0;
            EXE_rd_addr   <= 5'd0;
            EXE_funct3    <= 3'd0;
        end else if (exe_stall) begin
            EXE_RDSrc     <= 1'b0;
            EXE_MemtoReg  <= 1'b0;
            EXE_MemWrite  <= 1'b0;
            EXE_MemRead   <= 1'b0;
            EXE_RegWrite  <= 1'b0;
        end else begin
            EXE_RDSrc     <= ctrl_v.rd_src;
            EXE_MemtoReg  <= ctrl_v.mem_to_reg;
            EXE_MemWrite  <= ctrl_v.mem_write;
            EXE_MemRead   <= ctrl_v.mem_read;
            EXE_RegWrite  <= ctrl_v.reg_write;
            EXE_pc_to_reg <= ID_pc + 32'd4;
            EXE_ALU_out   <= alu_result;
            EXE_rs2_data  <= rs2_fwd;
            EXE_rd_addr   <= ID_rd_addr;
            EXE_funct3    <= ID_funct3;
        end
    end

endmodule

// File: tb/tb_exe_stage.sv
// Bench for exe_stage: directed scenarios followed by randomized
// instructions, all compared against a behavioural reference model.
module tb_exe_stage;
    import exe_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        ID_valid;
    ctrl_t       ID_ctrl;
    alu_op_t     ID_alu_op;
    logic [2:0]  ID_funct3;
    logic [31:0] ID_pc, ID_imm, ID_rs1_data, ID_rs2_data;
    logic [4:0]  ID_rs1_addr, ID_rs2_addr, ID_rd_addr;
    logic [31:0] fwd_mem_data, fwd_wb_data;
    logic [4:0]  fwd_wb_rd_addr;
    logic        fwd_wb_RegWrite;
    logic        EXE_RDSrc, EXE_MemtoReg, EXE_MemWrite, EXE_MemRead, EXE_RegWrite;
    logic [31:0] EXE_pc_to_reg, EXE_ALU_out, EXE_rs2_data;
    logic [4:0]  EXE_rd_addr;
    logic [2:0]  EXE_funct3;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        exe_stall;

    exe_stage dut (
        .clk             (clk),
        .rst             (rst),
        .ID_valid        (ID_valid),
        .ID_ctrl         (ID_ctrl),
        .ID_alu_op       (ID_alu_op),
        .ID_funct3       (ID_funct3),
        .ID_pc           (ID_pc),
        .ID_imm          (ID_imm),
        .ID_rs1_data     (ID_rs1_data),
        .ID_rs2_data     (ID_rs2_data),
        .ID_rs1_addr     (ID_rs1_addr),
        .ID_rs2_addr     (ID_rs2_addr),
        .ID_rd_addr      (ID_rd_addr),
        .fwd_mem_data    (fwd_mem_data),
        .fwd_wb_data     (fwd_wb_data),
        .fwd_wb_rd_addr  (fwd_wb_rd_addr),
        .fwd_wb_RegWrite (fwd_wb_RegWrite),
        .EXE_RDSrc       (EXE_RDSrc),
        .EXE_MemtoReg    (EXE_MemtoReg),
        .EXE_MemWrite    (EXE_MemWrite),
        .EXE_MemRead     (EXE_MemRead),
        .EXE_RegWrite    (EXE_RegWrite),
        .EXE_pc_to_reg   (EXE_pc_to_reg),
        .EXE_ALU_out     (EXE_ALU_out),
        .EXE_rs2_data    (EXE_rs2_data),
        .EXE_rd_addr     (EXE_rd_addr),
        .EXE_funct3      (EXE_funct3),
        .branch_taken    (branch_taken),
        .branch_target   (branch_target),
        .exe_stall       (exe_stall)
    );

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];
    logic        m_rw = 1'b0;   // expected EXE_RegWrite
    logic [4:0]  m_rd = 5'd0;   // expected EXE_rd_addr

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] m_fwd(input logic [4:0] addr, input logic [31:0] rf);
        if (addr == 5'd0) return rf;
        if (m_rw && m_rd == addr) return fwd_mem_data;
        if (fwd_wb_RegWrite && fwd_wb_rd_addr == addr) return fwd_wb_data;
        return rf;
    endfunction

    function automatic logic [31:0] ref_alu(input alu_op_t op, input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] pc, input logic [31:0] imm);
        longint      p;
        logic [63:0] u;
        int          sa, sb;
        int unsigned sh;
        sa = a;
        sb = b;
        sh = b % 32;
        case (op)
            ALU_ADD:    return a + b;
            ALU_SUB:    return a - b;
            ALU_SLL:    return a << sh;
            ALU_SLT:    return (sa < sb) ? 32'd1 : 32'd0;
            ALU_SLTU:   return (a < b) ? 32'd1 : 32'd0;
            ALU_XOR:    return a ^ b;
            ALU_SRL:    return a >> sh;
            ALU_SRA:    return sa >>> sh;
            ALU_OR:     return a | b;
            ALU_AND:    return a & b;
            ALU_LUI:    return imm;
            ALU_AUIPC:  return pc + imm;
            ALU_MUL: begin
                p = longint'(sa) * longint'(sb);
                return p[31:0];
            end
            ALU_MULH: begin
                p = longint'(sa) * longint'(sb);
                return p[63:32];
            end
            ALU_MULHSU: begin
                p = longint'(sa) * longint'({32'd0, b});
                return p[63:32];
            end
            ALU_MULHU: begin
                u = {32'd0, a} * {32'd0, b};
                return u[63:32];
            end
            ALU_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return sa / sb;
            end
            ALU_REM: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return sa % sb;
            end
            ALU_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            ALU_REMU:   return (b == 0) ? a : a % b;
            default:    return 32'd0;
        endcase
    endfunction

    function automatic logic ref_cond(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = a;
        sb = b;
        case (f3)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return sa < sb;
            3'd5: return sa >= sb;
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_fwd(input logic [31:0] mem, input logic [31:0] wb, input logic [4:0] wb_rd, input logic wb_we);
        fwd_mem_data    = mem;
        fwd_wb_data     = wb;
        fwd_wb_rd_addr  = wb_rd;
        fwd_wb_RegWrite = wb_we;
    endtask

    task automatic drive(input logic valid, input alu_op_t op, input ctrl_t c, input logic [2:0] f3,
                         input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] r1d,
                         input logic [31:0] r2d, input logic [4:0] r1a, input logic [4:0] r2a,
                         input logic [4:0] rd);
        ID_valid    = valid;
        ID_alu_op   = op;
        ID_ctrl     = c;
        ID_funct3   = f3;
        ID_pc       = pc;
        ID_imm      = imm;
        ID_rs1_data = r1d;
        ID_rs2_data = r2d;
        ID_rs1_addr = r1a;
        ID_rs2_addr = r2a;
        ID_rd_addr  = rd;
    endtask

    // Presents one instruction, checks the redirect, follows any stall and
    // then checks the EXE/MEM register. Starts and ends 1 time unit after
    // a rising edge.
    task automatic issue(input logic valid, input alu_op_t op, input ctrl_t c, input logic [2:0] f3,
                         input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] r1d,
                         input logic [31:0] r2d, input logic [4:0] r1a, input logic [4:0] r2a,
                         input logic [4:0] rd, output int nst);
        logic [31:0] a, s2, b, exp_alu, exp_tgt;
        logic        exp_tk, is_div, fast;
        logic [4:0]  exp_ctrl;
        int          exp_stall;
        drive(valid, op, c, f3, pc, imm, r1d, r2d, r1a, r2a, rd);
        a  = m_fwd(r1a, r1d);
        s2 = m_fwd(r2a, r2d);
        b  = c.alu_src ? imm : s2;
        is_div = (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
        fast   = (b == 0) || ((op == ALU_DIV || op == ALU_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        exp_stall = (valid && is_div && !fast) ? 33 : 0;
        exp_q.push_back(ref_alu(op, a, b, pc, imm));
        exp_tk  = valid && (c.jal || c.jalr || (c.branch && ref_cond(f3, a, s2)));
        exp_tgt = c.jalr ? ((a + imm) & 32'hFFFF_FFFE) : (pc + imm);
        exp_ctrl = valid ? {c.rd_src, c.mem_to_reg, c.mem_write, c.mem_read, c.reg_write} : 5'd0;
        #1;
        check("taken", 32'(branch_taken), 32'(exp_tk));
        if (exp_tk) check("target", branch_target, exp_tgt);
        nst = 0;
        while (exe_stall && nst < 100) begin
            nst++;
            @(posedge clk);
            #1;
            check("bubble", 32'({EXE_RDSrc, EXE_MemtoReg, EXE_MemWrite, EXE_MemRead, EXE_RegWrite}), 32'd0);
        end
        check("stall_cycles", 32'(nst), 32'(exp_stall));
        @(posedge clk);
        #1;
        exp_alu = exp_q.pop_front();
        check("ctrl", 32'({EXE_RDSrc, EXE_MemtoReg, EXE_MemWrite, EXE_MemRead, EXE_RegWrite}), 32'(exp_ctrl));
        if (valid) begin
            check("alu_out", EXE_ALU_out, exp_alu);
            check("pc_to_reg", EXE_pc_to_reg, pc + 32'd4);
            check("rd_addr", 32'(EXE_rd_addr), 32'(rd));
            check("funct3", 32'(EXE_funct3), 32'(f3));
            if (!is_div) check("rs2_data", EXE_rs2_data, s2);
        end
        m_rw = valid && c.reg_write;
        m_rd = rd;
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        ctrl_t c;
        int    nst;
        rst = 1'b1;
        drive(1'b0, ALU_ADD, '0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
        set_fwd(32'd0, 32'd0, 5'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_stall", 32'(exe_stall), 32'd0);
        check("rst_ctrl", 32'({EXE_RDSrc, EXE_MemtoReg, EXE_MemWrite, EXE_MemRead, EXE_RegWrite}), 32'd0);
        check("rst_alu", EXE_ALU_out, 32'd0);
        check("rst_pc", EXE_pc_to_reg, 32'd0);
        rst = 1'b0;

        // Forwarding priority
        c = '0;
        c.reg_write = 1'b1;
        issue(1'b1, ALU_ADD, c, 3'd0, 32'h100, 32'd0, 32'd2, 32'd3, 5'd0, 5'd0, 5'd1, nst);
        set_fwd(32'd5, 32'd9, 5'd1, 1'b1);
        issue(1'b1, ALU_ADD, c, 3'd0, 32'h104, 32'd0, 32'h77, 32'd0, 5'd1, 5'd0, 5'd2, nst);
        check("fwd_mem_prio", EXE_ALU_out, 32'd5);
        issue(1'b1, ALU_ADD, c, 3'd0, 32'h108, 32'd0, 32'h77, 32'd0, 5'd1, 5'd0, 5'd0, nst);
        check("fwd_wb", EXE_ALU_out, 32'd9);
        set_fwd(32'd5, 32'd9, 5'd0, 1'b1);
        issue(1'b1, ALU_ADD, c, 3'd0, 32'h10C, 32'd0, 32'h11, 32'd0, 5'd0, 5'd0, 5'd2, nst);
        check("x0_no_fwd", EXE_ALU_out, 32'h11);

        // Iterative divide
        set_fwd(32'd0, 32'd0, 5'd0, 1'b0);
        issue(1'b1, ALU_DIV, c, 3'd0, 32'h200, 32'd0, 32'hFFFF_FFF9, 32'd2, 5'd14, 5'd15, 5'd4, nst);
        check("div_val", EXE_ALU_out, 32'hFFFF_FFFD);
        check("div_stall", 32'(nst), 32'd33);
        check("div_regwrite", 32'(EXE_RegWrite), 32'd1);
        issue(1'b1, ALU_REM, c, 3'd0, 32'h204, 32'd0, 32'hFFFF_FFF9, 32'd2, 5'd14, 5'd15, 5'd4, nst);
        check("rem_val", EXE_ALU_out, 32'hFFFF_FFFF);

        // Fast path
        issue(1'b1, ALU_DIVU, c, 3'd0, 32'h208, 32'd0, 32'd5, 32'd0, 5'd14, 5'd15, 5'd4, nst);
        check("divu_zero", EXE_ALU_out, 32'hFFFF_FFFF);
        check("divu_zero_stall", 32'(nst), 32'd0);
        issue(1'b1, ALU_REM, c, 3'd0, 32'h20C, 32'd0, 32'd5, 32'd0, 5'd14, 5'd15, 5'd4, nst);
        check("rem_zero", EXE_ALU_out, 32'd5);
        issue(1'b1, ALU_DIV, c, 3'd0, 32'h210, 32'd0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 5'd15, 5'd4, nst);
        check("div_ovf", EXE_ALU_out, 32'h8000_0000);
        check("div_ovf_stall", 32'(nst), 32'd0);

        // Branches and jumps
        c = '0;
        c.branch = 1'b1;
        issue(1'b1, ALU_SUB, c, 3'd4, 32'h100, 32'h20, 32'hFFFF_FFFF, 32'd1, 5'd10, 5'd11, 5'd0, nst);
        check("blt_taken", 32'(branch_taken), 32'd1);
        check("blt_target", branch_target, 32'h120);
        issue(1'b1, ALU_SUB, c, 3'd6, 32'h100, 32'h20, 32'hFFFF_FFFF, 32'd1, 5'd10, 5'd11, 5'd0, nst);
        check("bltu_taken", 32'(branch_taken), 32'd0);
        c = '0;
        c.jalr = 1'b1;
        c.reg_write = 1'b1;
        c.rd_src = 1'b1;
        c.alu_src = 1'b1;
        issue(1'b1, ALU_ADD, c, 3'd0, 32'h300, 32'd0, 32'h203, 32'd0, 5'd10, 5'd0, 5'd1, nst);
        check("jalr_target", branch_target, 32'h202);
        check("jalr_link", EXE_pc_to_reg, 32'h304);

        // High multiplies
        c = '0;
        c.reg_write = 1'b1;
        issue(1'b1, ALU_MULH, c, 3'd0, 32'h400, 32'd0, 32'h8000_0000, 32'h8000_0000, 5'd12, 5'd13, 5'd3, nst);
        check("mulh", EXE_ALU_out, 32'h4000_0000);
        issue(1'b1, ALU_MULHU, c, 3'd0, 32'h404, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12, 5'd13, 5'd3, nst);
        check("mulhu", EXE_ALU_out, 32'hFFFF_FFFE);

        // Reset in the middle of a divide
        drive(1'b1, ALU_DIV, c, 3'd0, 32'h500, 32'd0, 32'hFFFF_FFF9, 32'd2, 5'd14, 5'd15, 5'd4);
        repeat (11) @(posedge clk);
        #1;
        check("busy_before_rst", 32'(exe_stall), 32'd1);
        rst = 1'b1;
        #1;
        check("abort_stall", 32'(exe_stall), 32'd0);
        check("abort_ctrl", 32'({EXE_RDSrc, EXE_MemtoReg, EXE_MemWrite, EXE_MemRead, EXE_RegWrite}), 32'd0);
        check("abort_alu", EXE_ALU_out, 32'd0);
        check("abort_pc", EXE_pc_to_reg, 32'd0);
        check("abort_rs2", EXE_rs2_data, 32'd0);
        check("abort_rd", 32'({EXE_rd_addr, EXE_funct3}), 32'd0);
        ID_valid = 1'b0;
        @(posedge clk);
        #1;
        rst  = 1'b0;
        m_rw = 1'b0;
        m_rd = 5'd0;
        issue(1'b1, ALU_ADD, c, 3'd0, 32'h600, 32'd0, 32'd40, 32'd2, 5'd14, 5'd15, 5'd4, nst);
        check("post_rst_add", EXE_ALU_out, 32'd42);
        check("post_rst_stall", 32'(nst), 32'd0);

        // Randomized instructions
        for (int i = 0; i < 300; i++) begin
            logic    v;
            alu_op_t op;
            logic [2:0] f3;
            v  = ($urandom_range(0, 9) != 0);
            op = alu_op_t'($urandom_range(0, 19));
            c  = ctrl_t'($urandom_range(0, 511));
            c.jal  = ($urandom_range(0, 7) == 0);
            c.jalr = !c.jal && ($urandom_range(0, 7) == 0);
            f3 = 3'($urandom_range(0, 7));
            set_fwd(rnd_val(), rnd_val(), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            issue(v, op, c, f3, $urandom & 32'hFFFF_FFFC, rnd_val(), rnd_val(), rnd_val(),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), nst);
        end

        // ---------------- final report ----------------
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, %0d checks done", n_checks);
        $fatal(1);
    end

endmodule
